fme_satd_accum: RTL and testbench

- Stage directly upstream of the FME 9-candidate best-selection comparator.
- Accumulates per-candidate 4x4 SATD over all 4x4 sub-blocks of a partition, seeded with a per-candidate bias (motion-vector cost).
- Presents the nine 16-bit totals in the comparator's packed distortion format with a one-cycle enable pulse.

---
 rtl/fme_satd_accum_pkg.sv | 23 ++
 rtl/fme_sat_add.sv | 19 +
 rtl/fme_satd_accum.sv | 103 ++++++++++
 tb/tb_fme_satd_accum.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fme_satd_accum_pkg.sv
// Shared FME definitions: candidate count, widths and cost types used by the
// SATD accumulator and the downstream best-candidate comparator.
package fme_satd_accum_pkg;

    localparam int unsigned NCAND   = 9;
    localparam int unsigned SATD_W  = 14;
    localparam int unsigned COST_W  = 16;
    localparam int unsigned MAX_BLK = 16;

    typedef logic [COST_W-1:0] cost_t;
    typedef cost_t [NCAND-1:0] cost_vec_t;
    typedef logic [SATD_W-1:0] satd_t;
    typedef satd_t [NCAND-1:0] satd_vec_t;

    localparam cost_t COST_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StEmit  = 2'd2
    } fme_state_e;

endpackage

// File: rtl/fme_sat_add.sv
// Single saturating adder: 16-bit cost plus 14-bit SATD, clamped to COST_MAX.
module fme_sat_add
    import fme_satd_accum_pkg::*;
(
    input  cost_t a,
    input  satd_t b,
    output cost_t y
);

    logic [COST_W:0] sum;

    // A 17th-bit carry means the true sum exceeds the cost range. Because b is
    // never negative, an operand already at COST_MAX always stays there.
    always_comb begin
        sum = {1'b0, a} + {{(COST_W + 1 - SATD_W){1'b0}}, b};
        y   = sum[COST_W] ? COST_MAX : sum[COST_W-1:0];
    end

endmodule

// File: rtl/fme_satd_accum.sv
// Per-candidate SATD accumulator feeding the FME 9-candidate comparator.
// Seeds each lane with its bias on start, adds one sub-block of SATDs per
// satd_vld, and presents the totals with a one-cycle en pulse.
module fme_satd_accum
    import fme_satd_accum_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  logic [4:0] num_blk,
    input  cost_vec_t bias,
    input  logic      satd_vld,
    input  satd_vec_t satd_in,
    output logic      busy,
    output cost_vec_t distort,
    output logic      en
);

    fme_state_e state_q, state_d;
    cost_vec_t  acc_q, acc_d;
    cost_vec_t  distort_q, distort_d;
    logic [4:0] blk_cnt_q, blk_cnt_d;
    logic [4:0] target_q, target_d;
    cost_vec_t  sum;
    logic [4:0] eff_blk;

    for (genvar i = 0; i < NCAND; i++) begin : g_lane
        fme_sat_add u_sat_add (
            .a (acc_q[i]),
            .b (satd_in[i]),
            .y (sum[i])
        );
    end

    // Zero and anything above the maximum both mean a full 16x16 partition.
    always_comb begin
        if (num_blk == 5'd0 || num_blk > 5'(MAX_BLK)) begin
            eff_blk = 5'(MAX_BLK);
        end else begin
            eff_blk = num_blk;
        end
    end

    // Next-state and datapath update; distort only loads on the way into EMIT.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        distort_d = distort_q;
        blk_cnt_d = blk_cnt_q;
        target_d  = target_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d     = bias;
                    blk_cnt_d = 5'd0;
                    target_d  = eff_blk;
                    state_d   = StAccum;
                end
            end
            StAccum: begin
                if (satd_vld) begin
                    acc_d     = sum;
                    blk_cnt_d = blk_cnt_q + 5'd1;
                    if (blk_cnt_d == target_q) begin
                        distort_d = sum;
                        state_d   = StEmit;
                    end
                end
            end
            StEmit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            distort_q <= '0;
            blk_cnt_q <= 5'd0;
            target_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            distort_q <= distort_d;
            blk_cnt_q <= blk_cnt_d;
            target_q  <= target_d;
        end
    end

    // Outputs decode directly from state so en can never repeat back to back.
    always_comb begin
        busy    = (state_q != StIdle);
        en      = (state_q == StEmit);
        distort = distort_q;
    end

endmodule

// File: tb/tb_fme_satd_accum.sv
// Randomized self-checking bench for fme_satd_accum. Expected totals come from
// a plain-arithmetic model: min(bias + sum of SATDs, 0xFFFF) per lane.
module tb_fme_satd_accum;
    import fme_satd_accum_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      start;
    logic [4:0] num_blk;
    cost_vec_t bias;
    logic      satd_vld;
    satd_vec_t satd_in;
    logic      busy;
    cost_vec_t distort;
    logic      en;

    int n_checks;
    int n_fail;

    cost_vec_t bias_v;
    satd_vec_t satd_m [16];
    cost_vec_t prev_v;

    fme_satd_accum dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_blk  (num_blk),
        .bias     (bias),
        .satd_vld (satd_vld),
        .satd_in  (satd_in),
        .busy     (busy),
        .distort  (distort),
        .en       (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic satd_vec_t rand_satd();
        satd_vec_t v;
        for (int i = 0; i < NCAND; i++) v[i] = satd_t'($urandom_range(16'h3FFF));
        return v;
    endfunction

    function automatic cost_vec_t rand_bias(input int unsigned maxv);
        cost_vec_t v;
        for (int i = 0; i < NCAND; i++) v[i] = cost_t'($urandom_range(maxv));
        return v;
    endfunction

    function automatic cost_t model_cost(input int lane, input int nvalid);
        longint s;
        s = longint'(bias_v[lane]);
        for (int k = 0; k < nvalid; k++) s += longint'(satd_m[k][lane]);
        return (s > 65535) ? COST_MAX : cost_t'(s);
    endfunction

    // One whole partition: start, eff valids with random gaps, EMIT, back to IDLE.
    // With noise set, satd_vld accompanies start and start is held high in
    // ACCUM gaps and during EMIT; none of that may change the result.
    task automatic run_part(input string name, input logic [4:0] nb, input int gapmax,
                            input bit noise);
        int        eff;
        cost_vec_t exp_v;
        eff = (nb == 5'd0 || nb > 5'd16) ? 16 : int'(nb);
        for (int i = 0; i < NCAND; i++) exp_v[i] = model_cost(i, eff);

        start    = 1'b1;
        num_blk  = nb;
        bias     = bias_v;
        satd_vld = noise;
        satd_in  = rand_satd();
        tick();
        start    = 1'b0;
        satd_vld = 1'b0;
        num_blk  = 5'($urandom_range(31));
        bias     = rand_bias(65535);
        check_eq({name, "_busy_start"}, 144'(busy), 144'(1));
        check_eq({name, "_en_start"}, 144'(en), 144'(0));

        for (int k = 0; k < eff; k++) begin
            int g;
            g = (gapmax == 0) ? 0 : int'($urandom_range(gapmax));
            for (int j = 0; j < g; j++) begin
                satd_vld = 1'b0;
                satd_in  = rand_satd();
                start    = noise;
                tick();
                check_eq({name, "_en_gap"}, 144'(en), 144'(0));
                check_eq({name, "_hold_gap"}, 144'(distort), 144'(prev_v));
            end
            satd_vld = 1'b1;
            satd_in  = satd_m[k];
            start    = noise;
            tick();
            if (k < eff - 1) begin
                check_eq({name, "_en_early"}, 144'(en), 144'(0));
                check_eq({name, "_hold_acc"}, 144'(distort), 144'(prev_v));
            end else begin
                check_eq({name, "_en_pulse"}, 144'(en), 144'(1));
                check_eq({name, "_busy_emit"}, 144'(busy), 144'(1));
                check_eq({name, "_distort"}, 144'(distort), 144'(exp_v));
            end
        end

        // Start held in the EMIT cycle must not be taken.
        satd_vld = 1'b0;
        start    = noise;
        num_blk  = 5'd1;
        tick();
        check_eq({name, "_en_after"}, 144'(en), 144'(0));
        check_eq({name, "_idle_after"}, 144'(busy), 144'(0));
        check_eq({name, "_distort_stable"}, 144'(distort), 144'(exp_v));
        start  = 1'b0;
        prev_v = exp_v;
        tick();
        check_eq({name, "_still_idle"}, 144'(busy), 144'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        num_blk  = 5'd0;
        bias     = '0;
        satd_vld = 1'b0;
        satd_in  = '0;
        prev_v   = '0;

        tick();
        tick();
        check_eq("rst_busy", 144'(busy), 144'(0));
        check_eq("rst_en", 144'(en), 144'(0));
        check_eq("rst_distort", 144'(distort), 144'(0));
        rst_n = 1'b1;
        tick();

        // Basic: single block, lane i gets i+1, en two cycles after start edge.
        bias_v = '0;
        for (int i = 0; i < NCAND; i++) satd_m[0][i] = satd_t'(i + 1);
        run_part("basic", 5'd1, 0, 1'b0);

        // Full 16x16 partition with gaps.
        for (int i = 0; i < NCAND; i++) bias_v[i] = cost_t'(10 * i);
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < NCAND; i++) satd_m[k][i] = satd_t'(100);
        run_part("full", 5'd0, 3, 1'b0);

        // Saturation on lane 3, other lanes exact.
        bias_v    = rand_bias(1000);
        bias_v[3] = 16'hFF00;
        for (int k = 0; k < 4; k++) begin
            satd_m[k]    = rand_satd();
            satd_m[k][3] = 14'h3FFF;
        end
        run_part("sat", 5'd4, 1, 1'b0);

        // Bias already at the maximum stays there even with zero SATD.
        bias_v    = rand_bias(5000);
        bias_v[7] = COST_MAX;
        for (int k = 0; k < 3; k++) begin
            satd_m[k]    = rand_satd();
            satd_m[k][7] = '0;
        end
        run_part("bias_max", 5'd3, 2, 1'b0);

        // Protocol noise: satd_vld with start, start while busy and in EMIT.
        bias_v = rand_bias(20000);
        for (int k = 0; k < 5; k++) satd_m[k] = rand_satd();
        run_part("protocol", 5'd5, 2, 1'b1);

        // Clamp: 20 requested, exactly 16 valids complete it.
        bias_v = rand_bias(300);
        for (int k = 0; k < 16; k++) satd_m[k] = rand_satd();
        run_part("clamp", 5'd20, 1, 1'b1);

        // Reset mid-operation after 2 of 4 blocks.
        start    = 1'b1;
        num_blk  = 5'd4;
        bias     = rand_bias(65535);
        tick();
        start    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            satd_vld = 1'b1;
            satd_in  = rand_satd();
            tick();
        end
        satd_vld = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_eq("midrst_busy", 144'(busy), 144'(0));
        check_eq("midrst_en", 144'(en), 144'(0));
        check_eq("midrst_distort", 144'(distort), 144'(0));
        rst_n  = 1'b1;
        prev_v = '0;
        for (int j = 0; j < 4; j++) begin
            satd_vld = 1'b1;
            satd_in  = rand_satd();
            tick();
            check_eq("midrst_no_en", 144'(en), 144'(0));
            check_eq("midrst_idle", 144'(busy), 144'(0));
        end
        satd_vld = 1'b0;
        bias_v   = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NCAND; i++) satd_m[k][i] = satd_t'(5);
        run_part("post_rst", 5'd2, 1, 1'b0);

        // Randomized partitions, including large biases and out-of-range counts.
        for (int r = 0; r < 8; r++) begin
            bias_v = rand_bias((r % 2 == 0) ? 65535 : 2000);
            for (int k = 0; k < 16; k++) satd_m[k] = rand_satd();
            run_part("random", 5'($urandom_range(31)), 2, 1'(r % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
